// File: rtl/hazard_ctl_unit_pkg.sv
// Shared constants for the hazard/forwarding controller.
//   Bypass select encodings, canonical result latencies and the NOP word
//   used when a bubble is pushed into X.
package hazard_ctl_unit_pkg;
  localparam int          BYP_NONE = 0;   // operand from regfile
  localparam int          BYP_MX   = 1;   // forward from the M-stage result
  localparam int          BYP_WX   = 2;   // forward from the W-stage result
  localparam int          LAT_ALU  = 1;
  localparam int          LAT_LOAD = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;  // addi x0,x0,0
endpackage

// File: rtl/hazard_slot.sv
// One scoreboard slot: destination register, write enable and result latency
// of the instruction that sits in one stage after decode.
//   clk, rst_n : clock, async active-low clear
//   en         : shift enable (low = hold contents)
//   in_*       : entry arriving from the younger slot (or from decode)
//   valid/rd/wen/lat : current entry
module hazard_slot #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic [LAT_W-1:0]  in_lat,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic              wen,
  output logic [LAT_W-1:0]  lat
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rd    <= '0;
      wen   <= 1'b0;
      lat   <= '0;
    end else if (en) begin
      valid <= in_valid;
      rd    <= in_rd;
      wen   <= in_wen;
      lat   <= in_lat;
    end
  end
endmodule

// File: rtl/hazard_ctl_unit.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks destination registers of in-flight instructions in a shift chain of
// NUM_SLOTS slots (slot 1 = X), stalls decode on unresolvable RAW hazards and
// registers per-operand bypass selects for the instruction entering X.
//   clk, rst_n        : clock, async active-low reset
//   hold              : global freeze of slots, selects and counters
//   d_*               : decode instruction fields
//   kill_dx           : taken branch/jump in X squashes D
//   stall, bubble_x   : combinational decode stall / X bubble
//   rs1_byp_x, rs2_byp_x : registered bypass selects (0 = regfile, k = slot k+1)
//   stall_cnt, flush_cnt : perf counters, present only with HAZARD_PERF_CNT_EN
module hazard_ctl_unit
  import hazard_ctl_unit_pkg::*;
#(
  parameter int NUM_SLOTS = 3,
  parameter int REG_AW    = 5,
  parameter int LAT_W     = 2,
  parameter int BYP_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_rs1_used,
  input  logic              d_rs2_used,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_wen,
  input  logic [LAT_W-1:0]  d_lat,
  input  logic              kill_dx,
  output logic              stall,
  output logic              bubble_x,
  output logic [BYP_W-1:0]  rs1_byp_x,
  output logic [BYP_W-1:0]  rs2_byp_x,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);
  // index g holds slot g+1
  logic [NUM_SLOTS-1:0]             s_valid, s_wen, in_valid, in_wen;
  logic [NUM_SLOTS-1:0][REG_AW-1:0] s_rd, in_rd;
  logic [NUM_SLOTS-1:0][LAT_W-1:0]  s_lat, in_lat;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             used, unres;
  logic [1:0][BYP_W-1:0]  sel;

  assign src  = {d_rs2, d_rs1};
  assign used = {d_rs2_used, d_rs1_used};

  // Scan oldest to youngest so the youngest match has the last word.
  // A match in the last slot is covered by the write-through regfile.
  always_comb begin
    unres = '0;
    sel   = '0;
    for (int s = 0; s < 2; s++) begin
      for (int j = NUM_SLOTS; j >= 1; j--) begin
        if (used[s] && s_valid[j-1] && s_wen[j-1] &&
            s_rd[j-1] != '0 && s_rd[j-1] == src[s]) begin
          if (j < NUM_SLOTS) begin
            sel[s]   = BYP_W'(j);
            unres[s] = int'(s_lat[j-1]) > j;
          end else begin
            sel[s]   = BYP_W'(BYP_NONE);
            unres[s] = 1'b0;
          end
        end
      end
    end
  end

  assign stall    = d_valid & ~kill_dx & (|unres);
  assign bubble_x = stall | kill_dx | ~d_valid;

  assign in_valid[0] = ~bubble_x;
  assign in_rd[0]    = d_rd;
  assign in_wen[0]   = d_wen;
  assign in_lat[0]   = d_lat;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    if (g > 0) begin : g_chain
      assign in_valid[g] = s_valid[g-1];
      assign in_rd[g]    = s_rd[g-1];
      assign in_wen[g]   = s_wen[g-1];
      assign in_lat[g]   = s_lat[g-1];
    end
    hazard_slot #(.REG_AW(REG_AW), .LAT_W(LAT_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (~hold),
      .in_valid (in_valid[g]),
      .in_rd    (in_rd[g]),
      .in_wen   (in_wen[g]),
      .in_lat   (in_lat[g]),
      .valid    (s_valid[g]),
      .rd       (s_rd[g]),
      .wen      (s_wen[g]),
      .lat      (s_lat[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_byp_x <= '0;
      rs2_byp_x <= '0;
    end else if (!hold) begin
      rs1_byp_x <= bubble_x ? '0 : sel[0];
      rs2_byp_x <= bubble_x ? '0 : sel[1];
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      if (stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (kill_dx && d_valid && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctl_unit.sv
module tb_hazard_ctl_unit;
  localparam int NS = 3;

  logic        clk, rst_n, hold, d_valid, d_rs1_used, d_rs2_used, d_wen, kill_dx;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [1:0]  d_lat;
  logic        stall, bubble_x;
  logic [1:0]  rs1_byp_x, rs2_byp_x;
  logic [31:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctl_unit #(.NUM_SLOTS(NS), .REG_AW(5), .LAT_W(2), .BYP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .d_valid(d_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .d_rd(d_rd), .d_wen(d_wen), .d_lat(d_lat), .kill_dx(kill_dx),
    .stall(stall), .bubble_x(bubble_x), .rs1_byp_x(rs1_byp_x), .rs2_byp_x(rs2_byp_x),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted instructions tagged with the advance count at
  // which they entered X; distance from "now" gives the stage they occupy.
  typedef struct { int rd; bit wen; int lat; int t; } ent_t;
  ent_t hist[$];
  int   adv, m_stall_cnt, m_flush_cnt, m_byp1, m_byp2;

  function automatic int ecnt(input int c);
`ifdef HAZARD_PERF_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  // stage (1..NS) of the youngest in-flight writer of src, 0 if none
  function automatic int youngest(input int src, output int plat);
    int best = 0;
    plat = 0;
    foreach (hist[i]) begin
      int age = adv - hist[i].t + 1;
      if (hist[i].wen && hist[i].rd != 0 && hist[i].rd == src && age <= NS &&
          (best == 0 || age < best)) begin
        best = age;
        plat = hist[i].lat;
      end
    end
    return best;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_d(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit w, input int lat, input bit k);
    d_valid = v; d_rs1 = 5'(r1); d_rs1_used = u1; d_rs2 = 5'(r2); d_rs2_used = u2;
    d_rd = 5'(rd); d_wen = w; d_lat = 2'(lat); kill_dx = k;
  endtask

  task automatic do_reset();
    hold = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    tick();
    hist.delete(); adv = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_byp1 = 0; m_byp2 = 0;
  endtask

  task automatic test_reset();
    hold = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_tests++; if (bubble_x !== 1'b1) begin n_fail++; $display("FAIL reset_bubble got %b exp 1", bubble_x); end
    n_tests++; if (rs1_byp_x !== 2'd0 || rs2_byp_x !== 2'd0) begin n_fail++; $display("FAIL reset_byp got %0d/%0d exp 0/0", rs1_byp_x, rs2_byp_x); end
    n_tests++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    do_reset();
  endtask

  task automatic test_mx();
    do_reset();
    set_d(1, 1, 1, 2, 1, 5, 1, 1, 0); tick();       // ADD x5,x1,x2
    set_d(1, 5, 1, 3, 1, 6, 1, 1, 0); #1;           // ADD x6,x5,x3
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mx_stall got %b exp 0", stall); end
    tick();
    n_tests++; if (rs1_byp_x !== 2'd1 || rs2_byp_x !== 2'd0) begin n_fail++; $display("FAIL mx_byp got %0d/%0d exp 1/0", rs1_byp_x, rs2_byp_x); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1, 1, 1, 0, 0, 5, 1, 2, 0); tick();       // LW x5,0(x1)
    set_d(1, 5, 1, 0, 0, 6, 1, 1, 0); #1;           // ADDI x6,x5,1
    n_tests++; if (stall !== 1'b1 || bubble_x !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b/%b exp 1/1", stall, bubble_x); end
    tick();
    n_tests++; if (rs1_byp_x !== 2'd0) begin n_fail++; $display("FAIL lu_bubble_byp got %0d exp 0", rs1_byp_x); end
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b exp 0", stall); end
    tick();
    n_tests++; if (rs1_byp_x !== 2'd2) begin n_fail++; $display("FAIL lu_byp got %0d exp 2", rs1_byp_x); end
    n_tests++; if (stall_cnt !== 32'(ecnt(1))) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt, ecnt(1)); end
  endtask

  task automatic test_wx_youngest();
    do_reset();
    set_d(1, 1, 1, 2, 1, 5, 1, 1, 0); tick();       // ADD x5
    set_d(1, 0, 1, 0, 0, 0, 1, 1, 0); tick();       // NOP
    set_d(1, 5, 1, 5, 1, 7, 1, 1, 0); #1;           // SUB x7,x5,x5
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wx_stall got %b exp 0", stall); end
    tick();
    n_tests++; if (rs1_byp_x !== 2'd2 || rs2_byp_x !== 2'd2) begin n_fail++; $display("FAIL wx_byp got %0d/%0d exp 2/2", rs1_byp_x, rs2_byp_x); end
    set_d(1, 1, 1, 2, 1, 5, 1, 1, 0); tick();       // x5 producer -> M
    set_d(1, 3, 1, 4, 1, 5, 1, 1, 0); tick();       // younger x5 producer
    set_d(1, 5, 1, 0, 1, 8, 1, 1, 0); tick();       // ADD x8,x5,x0
    n_tests++; if (rs1_byp_x !== 2'd1 || rs2_byp_x !== 2'd0) begin n_fail++; $display("FAIL youngest_byp got %0d/%0d exp 1/0", rs1_byp_x, rs2_byp_x); end
  endtask

  task automatic test_x0_nowen();
    do_reset();
    set_d(1, 0, 1, 0, 0, 0, 1, 1, 0); tick();       // ADDI x0,x0,1
    set_d(1, 0, 1, 0, 1, 3, 1, 1, 0); #1;           // ADD x3,x0,x0
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b exp 0", stall); end
    tick();
    n_tests++; if (rs1_byp_x !== 2'd0 || rs2_byp_x !== 2'd0) begin n_fail++; $display("FAIL x0_byp got %0d/%0d exp 0/0", rs1_byp_x, rs2_byp_x); end
    set_d(1, 1, 1, 2, 1, 5, 0, 2, 0); tick();       // BCC, rd field 5, no write
    set_d(1, 5, 1, 0, 0, 9, 1, 1, 0); #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nowen_stall got %b exp 0", stall); end
    tick();
    n_tests++; if (rs1_byp_x !== 2'd0) begin n_fail++; $display("FAIL nowen_byp got %0d exp 0", rs1_byp_x); end
  endtask

  task automatic test_kill_hold();
    do_reset();
    set_d(1, 1, 1, 0, 0, 5, 1, 2, 0); tick();       // LW x5
    set_d(1, 5, 1, 0, 0, 6, 1, 1, 1); #1;           // dependent, squashed
    n_tests++; if (stall !== 1'b0 || bubble_x !== 1'b1) begin n_fail++; $display("FAIL kill_comb got %b/%b exp 0/1", stall, bubble_x); end
    tick();
    n_tests++; if (flush_cnt !== 32'(ecnt(1)) || stall_cnt !== 32'd0) begin n_fail++; $display("FAIL kill_cnt got %0d/%0d exp %0d/0", flush_cnt, stall_cnt, ecnt(1)); end
    hold = 1'b1;
    set_d(1, 5, 1, 5, 1, 7, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (stall !== 1'b0 || bubble_x !== 1'b1) begin n_fail++; $display("FAIL hold_comb%0d got %b/%b exp 0/1", i, stall, bubble_x); end
      tick();
      n_tests++; if (rs1_byp_x !== 2'd0 || flush_cnt !== 32'(ecnt(1))) begin n_fail++; $display("FAIL hold_frozen%0d got byp %0d flush %0d exp 0/%0d", i, rs1_byp_x, flush_cnt, ecnt(1)); end
    end
    hold = 1'b0;
    kill_dx = 1'b0;
    tick();                                          // LW still in M when released
    n_tests++; if (rs1_byp_x !== 2'd2 || rs2_byp_x !== 2'd2) begin n_fail++; $display("FAIL hold_release_byp got %0d/%0d exp 2/2", rs1_byp_x, rs2_byp_x); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_d(1, 1, 1, 0, 0, 5, 1, 2, 0); tick();       // LW x5
    set_d(1, 5, 1, 0, 0, 6, 1, 1, 0); tick(); tick();
    n_tests++; if (rs1_byp_x !== 2'd2) begin n_fail++; $display("FAIL ar_pre_byp got %0d exp 2", rs1_byp_x); end
    set_d(1, 6, 1, 0, 0, 7, 1, 1, 0); tick();
    set_d(1, 7, 1, 0, 0, 8, 1, 2, 0); tick();       // LW x8 in X
    set_d(1, 8, 1, 0, 0, 9, 1, 1, 0); #1;
    n_tests++; if (stall !== 1'b1 || stall_cnt !== 32'(ecnt(1))) begin n_fail++; $display("FAIL ar_pre_stall got %b cnt %0d exp 1/%0d", stall, stall_cnt, ecnt(1)); end
    rst_n = 1'b0; #1;
    n_tests++; if (stall !== 1'b0 || rs1_byp_x !== 2'd0 || stall_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_clear got stall %b byp %0d cnt %0d exp 0/0/0", stall, rs1_byp_x, stall_cnt); end
    #1 rst_n = 1'b1; #1;
    n_tests++; if (stall !== 1'b0 || bubble_x !== 1'b0) begin n_fail++; $display("FAIL ar_after got %b/%b exp 0/0", stall, bubble_x); end
    tick();
    n_tests++; if (rs1_byp_x !== 2'd0 || stall_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_after_byp got %0d cnt %0d exp 0/0", rs1_byp_x, stall_cnt); end
  endtask

  task automatic test_random();
    int a1, a2, l1, l2, s1, s2;
    bit h1, h2, e_stall, e_bub;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(0, 99) < 15);
      set_d($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 99) < 80, $urandom_range(0, 3), $urandom_range(0, 99) < 10);
      a1 = youngest(int'(d_rs1), l1);
      a2 = youngest(int'(d_rs2), l2);
      h1 = d_rs1_used && a1 != 0 && a1 < NS && l1 > a1;
      h2 = d_rs2_used && a2 != 0 && a2 < NS && l2 > a2;
      s1 = (d_rs1_used && a1 != 0 && a1 < NS) ? a1 : 0;
      s2 = (d_rs2_used && a2 != 0 && a2 < NS) ? a2 : 0;
      e_stall = d_valid && !kill_dx && (h1 || h2);
      e_bub   = e_stall || kill_dx || !d_valid;
      #1;
      n_tests++; if (stall !== e_stall || bubble_x !== e_bub) begin n_fail++; $display("FAIL rnd_comb c%0d got %b/%b exp %b/%b", c, stall, bubble_x, e_stall, e_bub); end
      if (!hold) begin
        adv++;
        if (!e_bub) hist.push_back('{rd: int'(d_rd), wen: d_wen, lat: int'(d_lat), t: adv});
        while (hist.size() > 0 && adv - hist[0].t + 1 > NS) void'(hist.pop_front());
        m_byp1 = e_bub ? 0 : s1;
        m_byp2 = e_bub ? 0 : s2;
        if (e_stall) m_stall_cnt++;
        if (kill_dx && d_valid) m_flush_cnt++;
      end
      tick();
      n_tests++; if (rs1_byp_x !== 2'(m_byp1) || rs2_byp_x !== 2'(m_byp2)) begin n_fail++; $display("FAIL rnd_byp c%0d got %0d/%0d exp %0d/%0d", c, rs1_byp_x, rs2_byp_x, m_byp1, m_byp2); end
      n_tests++; if (stall_cnt !== 32'(ecnt(m_stall_cnt)) || flush_cnt !== 32'(ecnt(m_flush_cnt))) begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", c, stall_cnt, flush_cnt, ecnt(m_stall_cnt), ecnt(m_flush_cnt)); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_mx();
    test_load_use();
    test_wx_youngest();
    test_x0_nowen();
    test_kill_hold();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
